serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial WIDTH-bit adder that drives one 1-bit full-adder cell (a, b, cin -> sum, cout).
//   Each cycle it feeds the cell one operand bit pair, LSB first, and registers the carry between cycles.
//   Collects the sum bits into a result register and flags completion.
//   Sits directly upstream of the full-adder cell and feeds it; also consumes the cell's sum/cout.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      synchronous active-low reset
//   start    in   1      request; sampled only in IDLE or DONE
//   a_in     in   WIDTH  operand A, latched on accepted start
//   b_in     in   WIDTH  operand B, latched on accepted start
//   cin      in   1      initial carry, latched on accepted start
//   busy     out  1      high while in SHIFT
//   done     out  1      one-cycle pulse on entering DONE
//   sum_out  out  WIDTH  result, valid from the done pulse until the next accepted start
//   cout     out  1      final carry, same validity as sum_out
//   ovf      out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - state=IDLE; busy=0, done=0, sum_out=0, cout=0, ovf=0.
//     - Shift registers, carry register and bit counter all cleared.
//   FSM states: IDLE, SHIFT, DONE.
//     - IDLE --start--> SHIFT.
//     - SHIFT --after WIDTH bit cycles--> DONE.
//     - DONE --start--> SHIFT; otherwise DONE --> IDLE after one cycle.
//   Accepted start (state IDLE or DONE, start=1):
//     - a_sh<=a_in, b_sh<=b_in, c_reg<=cin, cnt<=0, sum_sh<=0.
//     - sum_out/cout/ovf keep their old values until overwritten at the next completion.
//   SHIFT, each cycle:
//     - Cell inputs: a_sh[0], b_sh[0], c_reg.
//     - a_sh and b_sh shift right by 1.
//     - Cell sum enters sum_sh at bit WIDTH-1; sum_sh shifts right.
//     - c_reg<=cell cout; cnt increments.
//   When cnt==WIDTH-1 in SHIFT:
//     - Next state DONE.
//     - sum_out<=final sum_sh; cout<=final cell cout.
//   Done pulse: done=1 for exactly the one cycle spent in DONE.
//   Latency: start accepted at edge N -> busy high for WIDTH cycles -> done high in cycle N+WIDTH+1.
//   start while busy=1: ignored, no effect on the operation in flight.
//   start held high in DONE: back-to-back operation, new operands latched; done still pulses exactly once.
//   Reset mid-SHIFT: operation aborted, all outputs return to reset values on that edge.
//   Arithmetic: {cout,sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1); no truncation beyond that.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined:
//     - Carry into the MSB is captured on the last SHIFT cycle.
//     - At completion, ovf<=carry_into_msb ^ final cout (two's-complement overflow); held like sum_out.
//   OVERFLOW_FLAG_EN undefined: no MSB-carry capture logic; ovf tied to 0. Port list is unchanged.
// TESTING  (WIDTH=8)
//   1. a=0x3C, b=0x25, cin=0, start 1 cycle -> busy 8 cycles; done in cycle 9; sum_out=0x61, cout=0.
//   2. a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout=1.
//   3. a=0x0F, b=0x01; pulse start again with a=0xAA at cycle 3 -> ignored; sum_out=0x10, one done pulse.
//   4. Start 0x80+0x80; rst_n=0 at cycle 4 -> busy=0, sum_out=0, cout=0 next edge; no done pulse.
//   5. start held high with a new operand pair -> second result correct; done pulses once per operation.
//   6. OVERFLOW_FLAG_EN: 0x7F+0x01 -> ovf=1; 0x80+0x80 -> ovf=1, cout=1; 0x10+0x20 -> ovf=0. Undefined: ovf=0 always.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder driving one full-adder cell, LSB first, with a registered carry between bits.
// Optional signed-overflow flag is enabled by defining OVERFLOW_FLAG_EN.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | one operand bit pair per cycle through the cell (busy)
// S_DONE  | result just written; done pulse; start here chains the next operation
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nx;
   logic             c_reg;
   logic [CW-1:0]    cnt;
   logic             cell_sum;
   logic             cell_cout;
   logic             accept;
   logic             last_bit;

   // Full-adder cell fed from the shift register LSBs and the carry register.
   assign cell_sum  = a_sh[0] ^ b_sh[0] ^ c_reg;
   assign cell_cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_reg) | (b_sh[0] & c_reg);

   assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
   assign last_bit = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
   assign sum_nx   = {cell_sum, sum_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_SHIFT;
         S_SHIFT: if (last_bit) state_nx = S_DONE;
         S_DONE:  state_nx = start ? S_SHIFT : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_SHIFT: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         c_reg   <= 1'b0;
         cnt     <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else if (accept) begin
         a_sh   <= a_in;
         b_sh   <= b_in;
         c_reg  <= cin;
         cnt    <= '0;
         sum_sh <= '0;
      end else if (state == S_SHIFT) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         sum_sh <= sum_nx;
         c_reg  <= cell_cout;
         cnt    <= cnt + 1'b1;
         if (last_bit) begin
            sum_out <= sum_nx;
            cout    <= cell_cout;
         end
      end
   end

`ifdef OVERFLOW_FLAG_EN
   // On the last bit c_reg is the carry into the MSB.
   always_ff @(posedge clk) begin
      if (!rst_n)        ovf <= 1'b0;
      else if (last_bit) ovf <= c_reg ^ cell_cout;
   end
`else
   assign ovf = 1'b0;
`endif

endmodule
